// File: rtl/nec_pkg.sv
// Shared types and pulse-width windows for the NEC infrared receiver.
// All windows are in microseconds, matching the 1 us measurement tick.
package nec_pkg;

    localparam int COUNT_W = 14;

    typedef logic [COUNT_W-1:0] count_t;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_LOW,
        LEAD_HIGH,
        BIT_LOW,
        BIT_HIGH,
        STOP,
        REP_STOP
    } state_t;

    localparam count_t COUNT_MAX     = 14'd16383;
    localparam count_t LEAD_LOW_MIN  = 14'd8000;
    localparam count_t LEAD_LOW_MAX  = 14'd10000;
    localparam count_t LEAD_HIGH_MIN = 14'd4000;
    localparam count_t LEAD_HIGH_MAX = 14'd5000;
    localparam count_t REP_MIN       = 14'd1800;
    localparam count_t REP_MAX       = 14'd2700;
    localparam count_t MARK_MIN      = 14'd400;
    localparam count_t MARK_MAX      = 14'd720;
    localparam count_t BIT0_MIN      = 14'd400;
    localparam count_t BIT0_MAX      = 14'd720;
    localparam count_t BIT1_MIN      = 14'd1400;
    localparam count_t BIT1_MAX      = 14'd1900;
    localparam count_t TIMEOUT       = 14'd12000;

    function automatic logic in_window(input count_t cnt, input count_t lo, input count_t hi);
        return (cnt >= lo) && (cnt <= hi);
    endfunction

endpackage

// File: rtl/ir_sync_edge.sv
// Two-flop synchroniser for the raw IR line followed by registered edge flags.
// Flops reset to the idle-high level so reset release never fakes an edge.
module ir_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            s3   <= 1'b1;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            s3   <= s2;
            rise <= s2 & ~s3;
            fall <= ~s2 & s3;
        end
    end

endmodule

// File: rtl/nec_ir_rx.sv
// NEC IR frame decoder: measures pulse widths in microseconds, decodes the
// 32-bit frame and hands the command byte to a busy-aware serial transmitter.
module nec_ir_rx
    import nec_pkg::*;
#(
    parameter int CLK_FREQ       = 50_000_000,
    parameter int TICK_DIV       = CLK_FREQ / 1_000_000,
    parameter bit CHECK_ADDR_INV = 1'b1
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       ir_in,
    input  logic       busy,
    output logic [7:0] data,
    output logic       data_en,
    output logic [7:0] addr,
    output logic       repeat_en,
    output logic       err,
    output logic       overflow
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic          rise, fall, edge_seen, tick;
    logic [PW-1:0] presc;
    count_t        count;
    state_t        state;
    logic [4:0]    bit_idx;
    logic [31:0]   shreg;
    logic [7:0]    cmd, pend_byte;
    logic          pending, frame_ok, accept;

    ir_sync_edge u_sync (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .din   (ir_in),
        .rise  (rise),
        .fall  (fall)
    );

    assign edge_seen = rise | fall;
    assign tick      = (presc == PW'(TICK_DIV - 1));

    // Prescaler restarts on each edge so durations are measured from the edge itself.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            presc <= '0;
            count <= '0;
        end else begin
            presc <= (edge_seen || tick) ? '0 : presc + 1'b1;
            if (edge_seen)
                count <= '0;
            else if (tick && count != COUNT_MAX)
                count <= count + 1'b1;
        end
    end

    // Frame bytes arrive LSB first: address, ~address, command, ~command.
    assign cmd = shreg[23:16];

    always_comb begin
        frame_ok = (shreg[31:24] == ~cmd);
        if (CHECK_ADDR_INV)
            frame_ok = frame_ok && (shreg[15:8] == ~shreg[7:0]);
        accept = (state == STOP) && rise && in_window(count, MARK_MIN, MARK_MAX) && frame_ok;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            bit_idx   <= '0;
            shreg     <= '0;
            addr      <= '0;
            err       <= 1'b0;
            repeat_en <= 1'b0;
        end else begin
            err       <= 1'b0;
            repeat_en <= 1'b0;
            if (state != IDLE && count >= TIMEOUT) begin
                err   <= 1'b1;
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (fall) state <= LEAD_LOW;
                    LEAD_LOW: if (rise) begin
                        if (in_window(count, LEAD_LOW_MIN, LEAD_LOW_MAX)) state <= LEAD_HIGH;
                        else begin err <= 1'b1; state <= IDLE; end
                    end
                    LEAD_HIGH: if (fall) begin
                        if (in_window(count, LEAD_HIGH_MIN, LEAD_HIGH_MAX)) begin
                            bit_idx <= '0;
                            state   <= BIT_LOW;
                        end else if (in_window(count, REP_MIN, REP_MAX)) begin
                            state <= REP_STOP;
                        end else begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    BIT_LOW: if (rise) begin
                        if (in_window(count, MARK_MIN, MARK_MAX)) state <= BIT_HIGH;
                        else begin err <= 1'b1; state <= IDLE; end
                    end
                    BIT_HIGH: if (fall) begin
                        if (in_window(count, BIT0_MIN, BIT0_MAX) || in_window(count, BIT1_MIN, BIT1_MAX)) begin
                            shreg <= {in_window(count, BIT1_MIN, BIT1_MAX), shreg[31:1]};
                            if (bit_idx == 5'd31) state <= STOP;
                            else begin
                                bit_idx <= bit_idx + 1'b1;
                                state   <= BIT_LOW;
                            end
                        end else begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    STOP: if (rise) begin
                        if (accept) addr <= shreg[7:0];
                        else        err  <= 1'b1;
                        state <= IDLE;
                    end
                    REP_STOP: if (rise) begin
                        if (in_window(count, MARK_MIN, MARK_MAX)) repeat_en <= 1'b1;
                        else                                      err       <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // One-deep holding register: an older pending byte always leaves before a newer one.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            data      <= '0;
            data_en   <= 1'b0;
            overflow  <= 1'b0;
            pending   <= 1'b0;
            pend_byte <= '0;
        end else begin
            data_en  <= 1'b0;
            overflow <= 1'b0;
            if (pending && !busy) begin
                data    <= pend_byte;
                data_en <= 1'b1;
                if (accept) pend_byte <= cmd;
                else        pending   <= 1'b0;
            end else if (accept) begin
                if (!busy && !pending) begin
                    data    <= cmd;
                    data_en <= 1'b1;
                end else begin
                    overflow  <= pending;
                    pend_byte <= cmd;
                    pending   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_nec_ir_rx.sv
// Self-checking bench for nec_ir_rx: directed NEC scenarios plus random frames
// judged by a byte-level model of frame validity and the output handshake.
module tb_nec_ir_rx;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       ir_in     = 1'b1;
    logic       busy      = 1'b0;
    logic [7:0] data, addr;
    logic       data_en, repeat_en, err, overflow;

    int checks = 0;
    int errors = 0;

    // One clock per microsecond keeps the run short while using real NEC timings.
    nec_ir_rx #(
        .CLK_FREQ       (1_000_000),
        .TICK_DIV       (1),
        .CHECK_ADDR_INV (1'b1)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .ir_in     (ir_in),
        .busy      (busy),
        .data      (data),
        .data_en   (data_en),
        .addr      (addr),
        .repeat_en (repeat_en),
        .err       (err),
        .overflow  (overflow)
    );

    always #5 sys_clk = ~sys_clk;

    int pos_cnt = 0;
    always @(posedge sys_clk) pos_cnt++;

    int         n_en = 0, n_err = 0, n_rep = 0, n_ovf = 0;
    int         en_pos = 0, err_pos = 0;
    logic [7:0] en_data = '0;

    always @(negedge sys_clk) begin
        if (data_en)   begin n_en++;  en_data = data; en_pos = pos_cnt; end
        if (err)       begin n_err++; err_pos = pos_cnt; end
        if (repeat_en) n_rep++;
        if (overflow)  n_ovf++;
    end

    logic [7:0] exp_data = '0;
    logic [7:0] exp_addr = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_accept(input logic [7:0] a, ai, c, ci);
        return (ci == (8'hFF ^ c)) && (ai == (8'hFF ^ a));
    endfunction

    task automatic hold(input logic lvl, input int us);
        ir_in = lvl;
        repeat (us) @(negedge sys_clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},      {24'd0, data}, 32'd0);
        check({tag, "_addr"},      {24'd0, addr}, 32'd0);
        check({tag, "_data_en"},   {31'd0, data_en}, 32'd0);
        check({tag, "_repeat_en"}, {31'd0, repeat_en}, 32'd0);
        check({tag, "_err"},       {31'd0, err}, 32'd0);
        check({tag, "_overflow"},  {31'd0, overflow}, 32'd0);
    endtask

    // Drives one frame; when rst_bit >= 0 the frame is cut by a reset during that bit.
    task automatic send_frame(input logic [7:0] a, ai, c, ci, input int rst_bit, output int stop_pos);
        logic [31:0] w;
        w = {ci, c, ai, a};
        stop_pos = -1;
        hold(1'b0, $urandom_range(8800, 9200));
        hold(1'b1, $urandom_range(4400, 4600));
        for (int i = 0; i < 32; i++) begin
            hold(1'b0, $urandom_range(520, 600));
            if (i == rst_bit) begin
                hold(1'b1, 200);
                sys_rst_n = 1'b0;
                #1;
                check_all_zero("midframe_rst");
                repeat (3) @(negedge sys_clk);
                sys_rst_n = 1'b1;
                hold(1'b1, 500);
                return;
            end
            hold(1'b1, w[i] ? $urandom_range(1620, 1760) : $urandom_range(520, 600));
        end
        hold(1'b0, $urandom_range(520, 600));
        ir_in    = 1'b1;
        stop_pos = pos_cnt;
        hold(1'b1, 300);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] a, ai, c, ci);
        int en0, err0, sp;
        bit ok;
        en0  = n_en;
        err0 = n_err;
        ok   = model_accept(a, ai, c, ci);
        send_frame(a, ai, c, ci, -1, sp);
        if (ok) begin
            exp_data = c;
            exp_addr = a;
        end
        check({tag, "_strobes"}, 32'(n_en - en0), ok ? 32'd1 : 32'd0);
        check({tag, "_errs"},    32'(n_err - err0), ok ? 32'd0 : 32'd1);
        check({tag, "_data"},    {24'd0, data}, {24'd0, exp_data});
        check({tag, "_addr"},    {24'd0, addr}, {24'd0, exp_addr});
        if (ok) check({tag, "_latency"}, 32'(en_pos - sp), 32'd4);
    endtask

    initial begin
        int         en0, err0, rep0, ovf0, sp, fall_pos;
        logic [7:0] a1, a2, ra, rc;
        logic [7:0] rai, rci;

        repeat (3) @(negedge sys_clk);
        check_all_zero("reset");
        sys_rst_n = 1'b1;
        hold(1'b1, 100);
        check_all_zero("after_reset");

        // Nominal frame, then a repeat code.
        run_frame("frame_a3", 8'h00, 8'hFF, 8'hA3, 8'h5C);
        rep0 = n_rep; en0 = n_en; err0 = n_err;
        hold(1'b0, 9000);
        hold(1'b1, 2250);
        hold(1'b0, 560);
        hold(1'b1, 300);
        check("repeat_pulses", 32'(n_rep - rep0), 32'd1);
        check("repeat_strobes", 32'(n_en - en0), 32'd0);
        check("repeat_errs", 32'(n_err - err0), 32'd0);
        check("repeat_data_hold", {24'd0, data}, 32'h0000_00A3);

        // Corrupted command inverse: err, addr and data unchanged.
        run_frame("bad_inv", 8'h44, 8'hBB, 8'hA2, 8'h5C);

        // Two frames while busy: second overwrites the pending byte.
        a1 = 8'($urandom);
        a2 = 8'($urandom);
        busy = 1'b1;
        en0 = n_en; ovf0 = n_ovf;
        send_frame(a1, ~a1, 8'h11, 8'hEE, -1, sp);
        check("busy1_strobes", 32'(n_en - en0), 32'd0);
        check("busy1_overflow", 32'(n_ovf - ovf0), 32'd0);
        send_frame(a2, ~a2, 8'h22, 8'hDD, -1, sp);
        check("busy2_overflow", 32'(n_ovf - ovf0), 32'd1);
        check("busy2_strobes", 32'(n_en - en0), 32'd0);
        busy = 1'b0;
        repeat (10) @(negedge sys_clk);
        exp_data = 8'h22;
        exp_addr = a2;
        check("release_strobes", 32'(n_en - en0), 32'd1);
        check("release_data", {24'd0, en_data}, 32'h0000_0022);
        check("release_addr", {24'd0, addr}, {24'd0, exp_addr});

        // Line stuck low after the leader: timeout error, then recovery.
        err0 = n_err; en0 = n_en;
        hold(1'b0, 9000);
        hold(1'b1, 4500);
        ir_in    = 1'b0;
        fall_pos = pos_cnt;
        hold(1'b0, 13000);
        hold(1'b1, 500);
        check("timeout_errs", 32'(n_err - err0), 32'd1);
        check("timeout_when", 32'((err_pos - fall_pos >= 12000) && (err_pos - fall_pos <= 12010)), 32'd1);
        check("timeout_strobes", 32'(n_en - en0), 32'd0);
        run_frame("after_timeout", 8'h3C, 8'hC3, 8'h5A, 8'hA5);

        // Reset during bit 15 discards the frame.
        en0 = n_en; err0 = n_err;
        send_frame(8'h12, 8'hED, 8'h34, 8'hCB, 15, sp);
        exp_data = 8'h00;
        exp_addr = 8'h00;
        check("rst_strobes", 32'(n_en - en0), 32'd0);
        check("rst_errs", 32'(n_err - err0), 32'd0);
        run_frame("after_rst", 8'h81, 8'h7E, 8'hC6, 8'h39);

        // Random frames, some with a corrupted inverse byte.
        for (int k = 0; k < 2; k++) begin
            ra  = 8'($urandom);
            rc  = 8'($urandom);
            rai = ~ra;
            rci = ~rc;
            case ($urandom_range(0, 2))
                1: rci = rci ^ (8'h01 << $urandom_range(0, 7));
                2: rai = rai ^ (8'h01 << $urandom_range(0, 7));
                default: ;
            endcase
            run_frame($sformatf("rand%0d", k), ra, rai, rc, rci);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nec_ir_rx.md
Name: nec_ir_rx

Overview:
- Decodes NEC infrared remote frames from a demodulated IR receiver output. Produces the command byte as a single-cycle `data`/`data_en` strobe in the format `uart_tx` consumes.
- Sits directly upstream of `uart_tx` and honours its `busy` output through a one-deep holding register.
- Also reports the address byte, repeat codes, protocol errors and dropped frames.

Parameters:
- CLK_FREQ, 50_000_000, `sys_clk` frequency in Hz.
- TICK_DIV, CLK_FREQ/1_000_000, clocks per 1 µs measurement tick.
- CHECK_ADDR_INV, 1, when 1 the address byte must be the bitwise inverse of its complement byte; when 0, extended NEC (16-bit address) is accepted.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  reset, asynchronous assert, active-low.
- ir_in  in  1  raw IR receiver output, asynchronous; idle high, burst = low.
- busy  in  1  from `uart_tx`; high while it is transmitting.
- data  out  8  decoded command byte.
- data_en  out  1  one-cycle strobe; `data` is valid in that cycle.
- addr  out  8  address byte of the last good frame.
- repeat_en  out  1  one-cycle pulse on a valid repeat code.
- err  out  1  one-cycle pulse on timing violation, inverse-check failure or timeout.
- overflow  out  1  one-cycle pulse when a pending byte is overwritten.

Behaviour:
- Reset:
  - All outputs 0.
  - FSM goes to IDLE; counters 0; pending flag 0.
  - Synchroniser flops reset to 1 (idle level).
  - Reset mid-frame discards the partial frame; no strobe is issued.
- Input path and latency:
  - `ir_in` passes through a 2-flop synchroniser, then a registered edge detector.
  - The FSM acts on the edge flag and registers its outputs.
  - Fixed latency is 4 `sys_clk` cycles from an `ir_in` transition to any resulting output pulse (with `busy`=0).
- Timing:
  - A prescaler produces a 1 µs tick.
  - A 14-bit µs counter clears on every detected edge and saturates at 16383.
  - Each duration is checked against its window on the edge that ends it.
- FSM (edge = synchronised edge):
  - IDLE: falling edge → LEAD_LOW.
  - LEAD_LOW: rising edge with count 8000..10000 → LEAD_HIGH; otherwise err → IDLE.
  - LEAD_HIGH: on falling edge:
    - 4000..5000 → BIT_LOW, bit index 0.
    - 1800..2700 → REP_STOP.
    - Otherwise err → IDLE.
  - BIT_LOW: rising edge with 400..720 → BIT_HIGH; otherwise err → IDLE.
  - BIT_HIGH: on falling edge:
    - 400..720 shifts in 0; 1400..1900 shifts in 1. Shifting is LSB first into a 32-bit register.
    - Otherwise err → IDLE.
    - After index 31 → STOP; else index+1 → BIT_LOW.
  - STOP: rising edge with 400..720:
    - If command == ~command_inv (and the address check passes when enabled): `addr` updated, frame accepted.
    - Otherwise err.
    - → IDLE in both cases.
  - REP_STOP: rising edge with 400..720 → `repeat_en` pulse; otherwise err. → IDLE.
- Byte order: address, ~address, command, ~command.
- Timeout: in any non-IDLE state, count reaching 12000 µs with no edge → err pulse, → IDLE.
- Output handshake:
  - Frame accepted with `busy`=0 and no pending byte: `data`=command, `data_en`=1 for one cycle.
  - Frame accepted with `busy`=1: command is stored in the pending register. `data_en` pulses on the first cycle in which `busy`=0.
  - Frame accepted while pending=1: the pending byte is overwritten with the newer command and `overflow` pulses.
  - Frame accept and pending release in the same cycle: the pending byte is issued first; the new byte becomes pending.
- `data` holds its value until the next strobe.
- `repeat_en` is independent of `busy` and is never queued.

Decomposition:
- Package `nec_pkg`:
  - FSM state enum: IDLE, LEAD_LOW, LEAD_HIGH, BIT_LOW, BIT_HIGH, STOP, REP_STOP.
  - µs window constants: LEAD_LOW min/max, LEAD_HIGH min/max, REP min/max, BIT0/BIT1/MARK min/max, TIMEOUT.
  - COUNT_W = 14.
- Sub-module `ir_sync_edge`: 2-flop synchroniser plus registered rise/fall detection, reset to idle level.
- Prescaler, counter, FSM and output holding logic live in `nec_ir_rx`.

Test Plan:
- Frame addr=0x00, cmd=0xA3 with nominal timing, `busy`=0 → exactly one `data_en`, `data`=0xA3, `addr`=0x00, 4 cycles after the stop-burst rising edge; `err`=0.
- Same frame, then repeat code (9 ms low, 2.25 ms high, 560 µs burst) → single `repeat_en` pulse; no `data_en`; `data` still 0xA3.
- Frame with cmd inverse byte 0x5D corrupted to 0x5C → `err` pulse at stop; no `data_en`; `addr` unchanged.
- `busy` held 1 during two consecutive frames (cmd 0x11, then 0x22) → `overflow` pulse on the second; after `busy` falls, one `data_en` with `data`=0x22.
- `ir_in` held low 13 ms after the leader rising edge (stuck mid-frame) → `err` at the 12000 µs timeout; FSM in IDLE; the next valid frame decodes correctly.
- `sys_rst_n` asserted during bit 15 → all outputs 0 immediately; no strobe; the following frame decodes normally.
